// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the UART receive path: receiver state
//            encoding, data width and the cycles-per-bit helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    // Integer division: any remainder is absorbed as a small rate error.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Generic two-flop synchronizer for a single asynchronous input.
//            The reset value is a parameter so an idle-high line can be held
//            at its idle level while reset is asserted.
// Ports    : clk   - destination clock
//            reset - asynchronous active-high reset
//            d_i   - asynchronous input
//            q_o   - synchronized output (two clk cycles of latency)
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : 8N1, LSB-first UART receiver. Turns the asynchronous rx pin into
//            one-cycle byte strobes for the ROM loader. Start-bit glitches are
//            rejected at mid start bit; a low stop bit raises a single
//            framing-error strobe and the receiver then waits for the line to
//            return high before looking for another start edge.
// Ports    : clk           - system clock
//            reset         - asynchronous active-high reset
//            rx            - raw serial line, idle high
//            data          - last correctly framed byte (held until replaced)
//            data_ready    - one-cycle strobe, data valid in the same cycle
//            framing_error - one-cycle strobe when the stop bit samples low
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_ready,
    output logic       framing_error
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    // Counter never exceeds CLKS_PER_BIT-1, so clog2 of the period suffices.
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIDX_W       = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIDX_W-1:0] LAST_BIT  = BIDX_W'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_receiver: CLK_FREQ/BAUD_RATE must be at least 4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input synchronizer; idle-high reset value so reset never looks like
    // a start edge.
    // ------------------------------------------------------------------
    logic rx_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [BIDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]  shreg_q,   shreg_d;
    logic [DATA_BITS-1:0]  data_q,    data_d;
    logic                  ready_q,   ready_d;
    logic                  ferr_q,    ferr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The counter runs freely inside a bit and is zeroed
    // on each sample and on every state entry; strobes default low so each
    // one lasts exactly the cycle after its sample.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // Line went back high before mid start bit: glitch.
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shreg_q;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end

            BREAK: begin
                // Swallow a held-low line until it recovers, so a break
                // yields one error rather than a stream of 0x00 bytes.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign data          = data_q;
    assign data_ready    = ready_q;
    assign framing_error = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Purpose  : Self-checking bench for uart_receiver at 16 clocks per bit.
//            A table of single frames is applied in a loop, followed by
//            hand-written sequences for back-to-back frames, start glitches,
//            break conditions and reset in mid-frame.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int unsigned CLK_FREQ  = 1600;
    localparam int unsigned BAUD_RATE = 100;
    localparam int          CPB       = 16;
    localparam int          LAT_NOM   = 2 + 8 + 9 * CPB;   // 154

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       data_ready;
    logic       framing_error;

    uart_receiver #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .data          (data),
        .data_ready    (data_ready),
        .framing_error (framing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe logger, sampled on the falling edge.
    int         dr_cnt  = 0;
    int         fe_cnt  = 0;
    bit         overlap = 1'b0;
    int         dr_cyc[$];
    logic [7:0] dr_dat[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (data_ready) begin
                dr_cnt <= dr_cnt + 1;
                dr_cyc.push_back(cyc);
                dr_dat.push_back(data);
            end
            if (framing_error) fe_cnt <= fe_cnt + 1;
            if (data_ready && framing_error) overlap <= 1'b1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act,
                             input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Drives one 8N1 frame starting at a falling clock edge.
    task automatic send_frame(input logic [7:0] b, input int p, input bit stop);
        rx = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (p) @(negedge clk);
        end
        rx = stop;
        repeat (p) @(negedge clk);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] val;
        int         period;
        bit         stop;
        logic [7:0] exp_data;
        int         exp_dr;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int base_dr, base_fe, base_q, t0;

        vecs[0] = '{val: 8'hA5, period: 16, stop: 1'b1, exp_data: 8'hA5, exp_dr: 1, exp_fe: 0};
        vecs[1] = '{val: 8'hC3, period: 15, stop: 1'b1, exp_data: 8'hC3, exp_dr: 1, exp_fe: 0};
        vecs[2] = '{val: 8'hC3, period: 17, stop: 1'b1, exp_data: 8'hC3, exp_dr: 1, exp_fe: 0};
        vecs[3] = '{val: 8'h3C, period: 16, stop: 1'b1, exp_data: 8'h3C, exp_dr: 1, exp_fe: 0};
        vecs[4] = '{val: 8'h5A, period: 16, stop: 1'b0, exp_data: 8'h3C, exp_dr: 0, exp_fe: 1};
        vecs[5] = '{val: 8'h0F, period: 16, stop: 1'b1, exp_data: 8'h0F, exp_dr: 1, exp_fe: 0};

        rx    = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_data", int'(data), 8'h00);
        chk("reset_ready", int'(data_ready), 0);
        chk("reset_ferr", int'(framing_error), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // ---------------- table-driven single frames ----------------
        for (int v = 0; v < 6; v++) begin
            base_dr = dr_cnt;
            base_fe = fe_cnt;
            base_q  = dr_cyc.size();
            t0      = cyc;
            send_frame(vecs[v].val, vecs[v].period, vecs[v].stop);
            repeat (40) @(negedge clk);
            chk($sformatf("vec%0d_ready_cnt", v), dr_cnt - base_dr, vecs[v].exp_dr);
            chk($sformatf("vec%0d_ferr_cnt", v), fe_cnt - base_fe, vecs[v].exp_fe);
            chk($sformatf("vec%0d_data", v), int'(data), int'(vecs[v].exp_data));
            if (vecs[v].period == CPB && vecs[v].exp_dr == 1 && dr_cyc.size() > base_q)
                chk_range($sformatf("vec%0d_latency", v), dr_cyc[base_q] - t0,
                          LAT_NOM - 2, LAT_NOM + 2);
        end

        // ---------------- back-to-back frames, no idle gap ----------------
        base_dr = dr_cnt;
        base_q  = dr_cyc.size();
        send_frame(8'h00, CPB, 1'b1);
        send_frame(8'hFF, CPB, 1'b1);
        send_frame(8'h55, CPB, 1'b1);
        repeat (40) @(negedge clk);
        chk("b2b_ready_cnt", dr_cnt - base_dr, 3);
        if (dr_cyc.size() >= base_q + 3) begin
            chk("b2b_data0", int'(dr_dat[base_q]),     8'h00);
            chk("b2b_data1", int'(dr_dat[base_q + 1]), 8'hFF);
            chk("b2b_data2", int'(dr_dat[base_q + 2]), 8'h55);
            chk_range("b2b_gap01", dr_cyc[base_q + 1] - dr_cyc[base_q], 158, 162);
            chk_range("b2b_gap12", dr_cyc[base_q + 2] - dr_cyc[base_q + 1], 158, 162);
        end

        // ---------------- start-bit glitch ----------------
        base_dr = dr_cnt;
        base_fe = fe_cnt;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_ready_cnt", dr_cnt - base_dr, 0);
        chk("glitch_ferr_cnt", fe_cnt - base_fe, 0);
        send_frame(8'h3C, CPB, 1'b1);
        repeat (40) @(negedge clk);
        chk("post_glitch_ready_cnt", dr_cnt - base_dr, 1);
        chk("post_glitch_data", int'(data), 8'h3C);

        // ---------------- framing error then held-low break ----------------
        base_dr = dr_cnt;
        base_fe = fe_cnt;
        send_frame(8'h81, CPB, 1'b0);
        rx = 1'b0;
        repeat (400) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("break_ferr_cnt", fe_cnt - base_fe, 1);
        chk("break_ready_cnt", dr_cnt - base_dr, 0);
        chk("break_data_kept", int'(data), 8'h3C);
        send_frame(8'h42, CPB, 1'b1);
        repeat (40) @(negedge clk);
        chk("post_break_ready_cnt", dr_cnt - base_dr, 1);
        chk("post_break_data", int'(data), 8'h42);

        // ---------------- reset in the middle of a frame ----------------
        rx = 1'b0;                                  // start bit of 0x96
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 1 || i == 2) ? 1'b1 : 1'b0;  // bits 0..3 of 0x96
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;                                  // bit 4 of 0x96
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_data", int'(data), 8'h00);
        chk("midreset_ready", int'(data_ready), 0);
        chk("midreset_ferr", int'(framing_error), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        base_dr = dr_cnt;
        base_fe = fe_cnt;
        send_frame(8'h69, CPB, 1'b1);
        repeat (40) @(negedge clk);
        chk("post_reset_ready_cnt", dr_cnt - base_dr, 1);
        chk("post_reset_ferr_cnt", fe_cnt - base_fe, 0);
        chk("post_reset_data", int'(data), 8'h69);

        chk("strobe_overlap", int'(overlap), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-byte front end of the UART program-load path; converts the asynchronous rx pin into one-cycle byte strobes.
- Format is 8N1, LSB first.
- Output data/data_ready pair feeds the ROM loader's byte input directly, so every strobe is exactly one valid byte.
- Rejects start-bit glitches and flags framing errors, so line noise at power-on or reset does not inject bytes.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- CLKS_PER_BIT (localparam), CLK_FREQ/BAUD_RATE (integer division), cycles per bit. Elaboration error if < 4.
- HALF_BIT (localparam), CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  raw serial line; asynchronous; idle high.
- data  output  8  last correctly framed byte.
- data_ready  output  1  one-cycle strobe; data is valid on the same cycle.
- framing_error  output  1  one-cycle strobe when the stop bit samples low.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (port reset). All flops use posedge clk / posedge reset.
- Reset values:
  - data = 8'h00, data_ready = 0, framing_error = 0.
  - Synchronizer flops = 1 (line idle).
  - state = IDLE; bit counter, cycle counter and shift register = 0.
- Input sync: rx passes through a 2-flop synchronizer. rx_s is the second flop output. All decisions use rx_s only.
- Cycle counter: cleared on every state entry and after every sample; increments once per cycle.
- IDLE:
  - rx_s == 0 → START.
- START:
  - Sample when counter == HALF_BIT-1.
  - rx_s == 1: glitch → IDLE; no strobes.
  - rx_s == 0 → DATA with bit index 0.
- DATA:
  - Sample when counter == CLKS_PER_BIT-1.
  - Shift right: shreg = {rx_s, shreg[7:1]}.
  - After bit index 7 is sampled → STOP.
- STOP:
  - Sample when counter == CLKS_PER_BIT-1.
  - rx_s == 1: data <= shreg; data_ready = 1 for exactly one cycle; → IDLE.
  - rx_s == 0: framing_error = 1 for exactly one cycle; data unchanged; → BREAK.
- BREAK:
  - Wait until rx_s == 1, then → IDLE. Held-low lines and break conditions therefore produce one error, not repeated bytes.
- Latency: nominal 2 + HALF_BIT + 9*CLKS_PER_BIT cycles from the rx falling edge at the pin to data_ready. Bench tolerance is ±2 cycles.
- Strobe rules:
  - data_ready and framing_error are never high together.
  - Each strobe is high for exactly one cycle.
  - Minimum spacing between strobes is 10*CLKS_PER_BIT - HALF_BIT cycles.
- Back-to-back frames: a start edge arriving while in STOP or BREAK is only honoured after return to IDLE. The next edge is detected on the first IDLE cycle in which rx_s == 0. No extra idle time is required.
- data holds the last good byte indefinitely. It is not cleared by framing errors.
- Reset mid-frame: immediate return to IDLE with outputs at reset values. The partial byte is discarded. The first complete frame after reset deasserts is received normally.
- No backpressure. The consumer must accept data on the data_ready cycle.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP, BREAK; 3 bits).
  - DATA_BITS = 8.
  - Function clks_per_bit(clk_freq, baud).
- One natural sub-module: sync_2ff (generic 2-flop synchronizer with parameterised reset value), reusable for other asynchronous pins.

Test Plan (CLK_FREQ=1600, BAUD_RATE=100 → CLKS_PER_BIT=16, HALF_BIT=8):
- Single frame 0xA5 with a 1-cycle stop margin → exactly one data_ready pulse at cycle ≈154 after the start edge; data == 8'hA5; framing_error never high.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap → three data_ready pulses, in order, about 160 cycles apart; data values 00, FF, 55.
- 5-cycle low glitch on idle rx → no data_ready and no framing_error. A following 0x3C frame is received correctly.
- Frame 0x81 with stop bit driven low, then rx held low for 400 cycles, then released → exactly one framing_error pulse; data retains its previous value. A subsequent 0x42 frame yields data_ready with data == 8'h42.
- reset asserted mid-frame (during bit 4 of 0x96) → outputs at reset values immediately. After release, frame 0x69 yields data == 8'h69 with no stray strobes.
- Baud tolerance: 0xC3 sent with a bit period of 15 and then 17 cycles (±6%) → correct byte both times.
